// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory sequencer: sizes and FSM encoding.
package imem_fetch_ctrl_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_AW    = 5;
  localparam int IMEM_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_out_reg.sv
// One-deep registered valid/ready output stage toward decode, with a flush that drops
// the buffered instruction regardless of o_ready.
module imem_fetch_ctrl_fetch_out_reg #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_flush,
  input  logic          i_ready,
  input  logic [DW-1:0] i_instr,
  input  logic [AW-1:0] i_pc,
  output logic          o_valid,
  output logic [DW-1:0] o_instr,
  output logic [AW-1:0] o_pc
);

  logic          r_valid;
  logic [DW-1:0] r_instr;
  logic [AW-1:0] r_pc;

  // Handshake: a word transfers on a cycle where o_valid and i_ready are both high;
  // while o_valid is high and i_ready low, o_instr/o_pc hold stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: loads a program through the loader stream, then walks
// the pc from 0 to prog_len, presenting each word to decode; accepts branch redirects.
module imem_fetch_ctrl #(
  parameter int DEPTH = imem_fetch_ctrl_pkg::IMEM_DEPTH,
  parameter int AW    = imem_fetch_ctrl_pkg::IMEM_AW,
  parameter int DW    = imem_fetch_ctrl_pkg::IMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          start,
  input  logic          halt_req,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [DW-1:0] imem_wdata,
  output logic [AW-1:0] imem_raddr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          fetch_valid,
  input  logic          fetch_ready,
  output logic [DW-1:0] fetch_instr,
  output logic [AW-1:0] fetch_pc,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);
  import imem_fetch_ctrl_pkg::*;

  state_t        r_state;
  logic [AW:0]   r_pc;
  logic [AW:0]   r_prog_len;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic          r_done;
  logic          r_err;

  logic          w_run;
  logic          w_ld_acc;
  logic          w_ld_end;
  logic          w_adv;
  logic          w_flush;
  logic          w_br_bad;
  logic [AW:0]   w_pc_inc;

  assign ld_ready = (r_state == ST_LOAD);
  assign w_run    = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_ld_acc = ld_valid && ld_ready;
  assign w_ld_end = ld_last || (r_wr_ptr == AW'(DEPTH - 1));
  assign w_pc_inc = r_pc + (AW + 1)'(1);
  assign w_br_bad = ({1'b0, br_target} >= r_prog_len);
  assign w_adv    = (r_state == ST_FETCH) && !halt_req && !br_taken &&
                    (!fetch_valid || fetch_ready) && (r_pc < r_prog_len);
  assign w_flush  = w_run && (halt_req || br_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_prog_len <= '0;
      r_wr_ptr   <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_req) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_err      <= 1'b0;
          end else if (start && (r_prog_len != '0)) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
          end
        end
        ST_LOAD: begin
          if (w_ld_acc) begin
            r_we       <= 1'b1;
            r_waddr    <= r_wr_ptr;
            r_wdata    <= ld_data;
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_prog_len <= r_prog_len + (AW + 1)'(1);
            if (w_ld_end) r_state <= ST_IDLE;
          end
          if (halt_req) r_state <= ST_IDLE;
        end
        ST_FETCH, ST_DRAIN: begin
          if (halt_req) begin
            r_state <= ST_IDLE;
          end else if (br_taken) begin
            r_pc <= {1'b0, br_target};
            if (w_br_bad) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_FETCH;
            end
          end else if (r_state == ST_FETCH) begin
            // Enter DRAIN as the last word is fetched so done follows its acceptance directly.
            if (w_adv) begin
              r_pc <= w_pc_inc;
              if (w_pc_inc == r_prog_len) r_state <= ST_DRAIN;
            end else if (r_pc >= r_prog_len) begin
              r_state <= ST_DRAIN;
            end
          end else if (!fetch_valid || fetch_ready) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  imem_fetch_ctrl_fetch_out_reg #(
    .AW(AW),
    .DW(DW)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_adv),
    .i_flush (w_flush),
    .i_ready (fetch_ready),
    .i_instr (imem_rdata),
    .i_pc    (r_pc[AW-1:0]),
    .o_valid (fetch_valid),
    .o_instr (fetch_instr),
    .o_pc    (fetch_pc)
  );

  assign imem_raddr = r_pc[AW-1:0];
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign prog_len   = r_prog_len;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle table for load + run, then directed stall, branch,
// full-depth load and mid-load reset sequences against a behavioural instruction memory.
module tb_imem_fetch_ctrl;
  import imem_fetch_ctrl_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;
  localparam int AW    = IMEM_AW;
  localparam int DW    = IMEM_DW;

  logic          clk;
  logic          rst;
  logic          load_req;
  logic          start;
  logic          halt_req;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [DW-1:0] imem_wdata;
  logic [AW-1:0] imem_raddr;
  logic [DW-1:0] imem_rdata;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [DW-1:0] fetch_instr;
  logic [AW-1:0] fetch_pc;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .load_req(load_req), .start(start), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .prog_len(prog_len), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // behavioural instruction memory
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign imem_rdata = mem[imem_raddr];

  int n_checks;
  int n_errors;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] prog [3];

  typedef struct {
    logic          load_req, start, ld_valid, ld_last, fetch_ready;
    logic [DW-1:0] ld_data;
    logic          e_ld_ready, e_we;
    logic [AW-1:0] e_waddr;
    logic          e_fv;
    logic [AW-1:0] e_fpc;
    logic          e_done, e_busy;
    logic [AW:0]   e_plen;
  } vec_t;
  vec_t vecs [12];

  function automatic vec_t mkv(input int lr, input int st, input int lv, input int ll,
                               input int fr, input logic [DW-1:0] d, input int rdy,
                               input int we, input int wa, input int fv, input int fpc,
                               input int dn, input int bz, input int pl);
    vec_t v;
    v.load_req = lr[0]; v.start = st[0]; v.ld_valid = lv[0]; v.ld_last = ll[0];
    v.fetch_ready = fr[0]; v.ld_data = d;
    v.e_ld_ready = rdy[0]; v.e_we = we[0]; v.e_waddr = wa[AW-1:0];
    v.e_fv = fv[0]; v.e_fpc = fpc[AW-1:0]; v.e_done = dn[0]; v.e_busy = bz[0];
    v.e_plen = pl[AW:0];
    return v;
  endfunction

  function automatic logic [DW-1:0] word_of(input int i);
    return 32'h5A00_0000 + DW'(i) * 32'h0001_0001;
  endfunction

  // driver / checker tasks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    load_req = 0; start = 0; halt_req = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    br_taken = 0; br_target = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic sb_accept();
    logic [AW+DW-1:0] e;
    if (fetch_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_extra actual=%0h expected=none", {fetch_pc, fetch_instr});
      end else begin
        e = exp_q.pop_front();
        chk("sb_fetch", {fetch_pc, fetch_instr}, e);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_waddr"}, imem_waddr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_raddr"}, imem_raddr, 0);
    chk({tag, "_fv"}, fetch_valid, 0);
    chk({tag, "_finstr"}, fetch_instr, 0);
    chk({tag, "_fpc"}, fetch_pc, 0);
    chk({tag, "_plen"}, prog_len, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int n_done;
    int stalls;
    int n_acc;
    int last_rdy;
    bit found;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    prog[0] = 32'h0C00_0000;
    prog[1] = 32'h0C01_0001;
    prog[2] = 32'h0C02_0002;
    clear_inputs();
    fetch_ready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    check_reset("rst0");

    // load 3 words then run them at full rate
    vecs[0]  = mkv(1,0,0,0,0, '0,      0,0,0, 0,0, 0,0,0);
    vecs[1]  = mkv(0,0,1,0,0, prog[0], 1,0,0, 0,0, 0,1,0);
    vecs[2]  = mkv(0,0,1,0,0, prog[1], 1,1,0, 0,0, 0,1,1);
    vecs[3]  = mkv(0,0,1,1,0, prog[2], 1,1,1, 0,0, 0,1,2);
    vecs[4]  = mkv(0,0,0,0,0, '0,      0,1,2, 0,0, 0,0,3);
    vecs[5]  = mkv(0,1,0,0,1, '0,      0,0,0, 0,0, 0,0,3);
    vecs[6]  = mkv(0,0,0,0,1, '0,      0,0,0, 0,0, 0,1,3);
    vecs[7]  = mkv(0,0,0,0,1, '0,      0,0,0, 1,0, 0,1,3);
    vecs[8]  = mkv(0,0,0,0,1, '0,      0,0,0, 1,1, 0,1,3);
    vecs[9]  = mkv(0,0,0,0,1, '0,      0,0,0, 1,2, 0,1,3);
    vecs[10] = mkv(0,0,0,0,1, '0,      0,0,0, 0,0, 1,0,3);
    vecs[11] = mkv(0,0,0,0,1, '0,      0,0,0, 0,0, 0,0,3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      load_req = vecs[i].load_req; start = vecs[i].start; ld_valid = vecs[i].ld_valid;
      ld_last = vecs[i].ld_last; fetch_ready = vecs[i].fetch_ready; ld_data = vecs[i].ld_data;
      #1;
      chk($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_ld_ready);
      chk($sformatf("v%0d_we", i), imem_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), imem_waddr, vecs[i].e_waddr);
        chk($sformatf("v%0d_wdata", i), imem_wdata, prog[vecs[i].e_waddr]);
      end
      chk($sformatf("v%0d_fv", i), fetch_valid, vecs[i].e_fv);
      if (vecs[i].e_fv) begin
        chk($sformatf("v%0d_fpc", i), fetch_pc, vecs[i].e_fpc);
        chk($sformatf("v%0d_finstr", i), fetch_instr, prog[vecs[i].e_fpc]);
      end
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_plen", i), prog_len, vecs[i].e_plen);
    end
    @(negedge clk); clear_inputs();

    // decode stalls 3 cycles while pc 1 is presented
    for (int i = 0; i < 3; i++) exp_q.push_back({AW'(i), prog[i]});
    fetch_ready = 1;
    pulse_start();
    n_done = 0; stalls = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fetch_valid && fetch_pc == 1 && stalls < 3) begin
        fetch_ready = 0;
        stalls++;
        chk("stall_hold_instr", fetch_instr, prog[1]);
      end else begin
        fetch_ready = 1;
      end
      #1;
      sb_accept();
      if (done) n_done++;
    end
    chk("stall_count", stalls, 3);
    chk("stall_q_empty", exp_q.size(), 0);
    chk("stall_done_once", n_done, 1);

    // branch to 0 while pc 2 is buffered, then halt
    fetch_ready = 1;
    pulse_start();
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (fetch_valid && fetch_pc == 2) begin
        br_taken = 1; br_target = '0; found = 1;
      end
    end
    chk("br_reached_pc2", found, 1);
    @(posedge clk); #1; br_taken = 0;
    chk("br_squash_fv", fetch_valid, 0);
    chk("br_no_done", done, 0);
    chk("br_state_fetch", dbg_state, 2);
    @(posedge clk); #1;
    chk("br_refetch_fv", fetch_valid, 1);
    chk("br_refetch_pc", fetch_pc, 0);
    chk("br_refetch_instr", fetch_instr, prog[0]);
    @(negedge clk); halt_req = 1;
    @(posedge clk); #1; halt_req = 0;
    chk("halt_busy", busy, 0);
    chk("halt_fv", fetch_valid, 0);
    chk("halt_no_done", done, 0);

    // out-of-range branch sets sticky err
    pulse_start();
    @(negedge clk); br_taken = 1; br_target = AW'(5);
    @(posedge clk); #1; br_taken = 0;
    chk("bad_br_err", err, 1);
    chk("bad_br_state", dbg_state, 0);
    chk("bad_br_fv", fetch_valid, 0);
    @(posedge clk); #1;
    chk("bad_br_err_sticky", err, 1);

    // 40-word stream with no ld_last: only DEPTH words are taken
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), word_of(i)});
    @(negedge clk); load_req = 1;
    @(posedge clk); #1; load_req = 0;
    chk("load_clears_err", err, 0);
    n_acc = 0; last_rdy = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); ld_valid = 1; ld_data = word_of(i);
      #1;
      if (ld_ready) begin n_acc++; last_rdy = i; end
    end
    @(negedge clk); ld_valid = 0; #1;
    chk("full_n_acc", n_acc, DEPTH);
    chk("full_last_rdy", last_rdy, DEPTH - 1);
    chk("full_plen", prog_len, DEPTH);
    chk("full_ld_ready", ld_ready, 0);
    fetch_ready = 1;
    pulse_start();
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      sb_accept();
      if (done) n_done++;
    end
    chk("full_q_empty", exp_q.size(), 0);
    chk("full_done_once", n_done, 1);
    chk("full_busy_end", busy, 0);
    chk("full_fv_end", fetch_valid, 0);

    // reset mid-load, then start must be ignored
    @(negedge clk); load_req = 1;
    @(posedge clk); #1; load_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); ld_valid = 1; ld_data = 32'hDEAD_0000 + DW'(k);
      @(posedge clk); #1;
    end
    @(negedge clk); ld_valid = 1; ld_data = 32'hDEAD_0002; rst = 1;
    @(posedge clk); #1; rst = 0; ld_valid = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk); #1;
    check_reset("rst_mid");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
